// File: rtl/encoder_apb_arbiter.sv
// Round-robin APB read master sharing the encoder's APB slave port between NREQ requesters.
// One transfer at a time; the winner gets prdata/pslverr back with a one-cycle done pulse.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | bus idle; pick the next eligible requester round-robin
// S_SETUP  | APB setup phase (psel=1, penable=0), wait counter cleared
// S_ACCESS | APB access phase; wait for pready or the wait-state watchdog
module encoder_apb_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_addr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [7:0]        paddr,
  input  logic [7:0]        prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   last, last_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt, wait_cnt_inc;
  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic [7:0]      rsp_data_nxt, paddr_nxt;
  logic            rsp_err_nxt, busy_nxt, psel_nxt, penable_nxt;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [LW-1:0]   pick, cand;

  // read-only master
  assign pwrite = 1'b0;

  // Round-robin search upward from last+1; the requester finishing this cycle sits out.
  always_comb begin
    elig  = req & ~done;
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = LW'((int'(last) + k) % NREQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign wait_cnt_inc = wait_cnt + 1'b1;

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    wait_cnt_nxt = wait_cnt;
    gnt_nxt      = gnt;
    done_nxt     = '0;
    rsp_data_nxt = rsp_data;
    rsp_err_nxt  = rsp_err;
    paddr_nxt    = paddr;
    psel_nxt     = psel;
    penable_nxt  = penable;
    busy_nxt     = busy;

    case (state)
      S_IDLE: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        busy_nxt    = 1'b0;
        gnt_nxt     = '0;
        if (found) begin
          gnt_nxt       = '0;
          gnt_nxt[pick] = 1'b1;
          paddr_nxt     = req_addr[{pick, 3'b000} +: 8];
          last_nxt      = pick;
          psel_nxt      = 1'b1;
          busy_nxt      = 1'b1;
          state_nxt     = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = S_ACCESS;
      end

      S_ACCESS: begin
        if (pready) begin
          rsp_data_nxt = prdata;
          rsp_err_nxt  = pslverr;
          done_nxt     = gnt;
          gnt_nxt      = '0;
          psel_nxt     = 1'b0;
          penable_nxt  = 1'b0;
          busy_nxt     = 1'b0;
          state_nxt    = S_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt_inc;
          // watchdog: abort with error once TIMEOUT wait cycles have elapsed
          if ((TIMEOUT != 0) && (wait_cnt_inc == TO_CNT)) begin
            rsp_data_nxt = 8'h00;
            rsp_err_nxt  = 1'b1;
            done_nxt     = gnt;
            gnt_nxt      = '0;
            psel_nxt     = 1'b0;
            penable_nxt  = 1'b0;
            busy_nxt     = 1'b0;
            state_nxt    = S_IDLE;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= S_IDLE;
      last     <= LAST_RST;
      wait_cnt <= '0;
      gnt      <= '0;
      done     <= '0;
      rsp_data <= 8'h00;
      rsp_err  <= 1'b0;
      paddr    <= 8'h00;
      psel     <= 1'b0;
      penable  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      wait_cnt <= wait_cnt_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      rsp_data <= rsp_data_nxt;
      rsp_err  <= rsp_err_nxt;
      paddr    <= paddr_nxt;
      psel     <= psel_nxt;
      penable  <= penable_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_encoder_apb_arbiter.sv
// Bench for encoder_apb_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (round-robin pick, access length, expected response).
module tb_encoder_apb_arbiter;
  localparam int NREQ = 2;
  localparam int TO   = 16;

  logic              pclk = 1'b0;
  logic              preset;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_addr;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        rsp_data, paddr, prdata;
  logic              rsp_err, busy, psel, penable, pwrite, pready, pslverr;

  encoder_apb_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset), .req(req), .req_addr(req_addr),
    .gnt(gnt), .done(done), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // requester side
  logic [7:0] aq [NREQ][$];
  bit  pend[NREQ], dropped[NREQ];
  int  req_start[NREQ];
  bit  hold_mode, allow_drop, stuck, rand_stuck;
  int  wait_fixed;

  // transaction-level model of the bus
  bit         inflight, x_stuck, x_abort;
  int         x_s, x_acc, x_own, x_waits, m_last, last_lat;
  logic [7:0] x_addr, exp_paddr, exp_rdata;
  logic       exp_rerr;
  logic [NREQ-1:0] done_prev;
  int         win_log[$], setup_log[$];

  function automatic bit work_left();
    bit w = inflight;
    for (int i = 0; i < NREQ; i++) if (aq[i].size() > 0) w = 1'b1;
    return w;
  endfunction

  task automatic model_reset();
    inflight  = 1'b0;
    m_last    = NREQ - 1;
    exp_paddr = 8'h00;
    exp_rdata = 8'h00;
    exp_rerr  = 1'b0;
    done_prev = '0;
  endtask

  task automatic step();
    logic [NREQ-1:0] elig, exp_gnt, exp_done;
    bit setup_now, acc_now, done_now, in_prev, found, busy_exp;
    int idx, w;
    @(negedge pclk);
    cyc++;
    elig      = req & ~done_prev;
    in_prev   = inflight;
    setup_now = 1'b0;
    acc_now   = 1'b0;
    done_now  = 1'b0;
    exp_done  = '0;
    if (inflight && cyc == x_s + x_acc + 1) begin
      done_now           = 1'b1;
      inflight           = 1'b0;
      exp_done[x_own]    = 1'b1;
      exp_rdata          = x_abort ? 8'h00 : (x_addr ^ 8'hA5);
      exp_rerr           = x_abort | (x_addr > 8'd7);
    end else if (inflight) begin
      acc_now = 1'b1;
    end
    if (!in_prev && elig != '0) begin
      found = 1'b0;
      w     = 0;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (!found && elig[idx]) begin found = 1'b1; w = idx; end
      end
      m_last    = w;
      setup_now = 1'b1;
      inflight  = 1'b1;
      x_s       = cyc;
      x_own     = w;
      x_addr    = aq[w][0];
      x_waits   = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 4));
      x_stuck   = stuck || (rand_stuck && $urandom_range(0, 11) == 0);
      x_abort   = x_stuck || (x_waits >= TO);
      x_acc     = x_abort ? TO : x_waits + 1;
      exp_paddr = x_addr;
      win_log.push_back(w);
      setup_log.push_back(cyc);
    end
    busy_exp = setup_now | acc_now;
    exp_gnt  = '0;
    if (busy_exp) exp_gnt[x_own] = 1'b1;

    chk("psel",     psel,     busy_exp);
    chk("penable",  penable,  acc_now);
    chk("busy",     busy,     busy_exp);
    chk("gnt",      gnt,      exp_gnt);
    chk("done",     done,     exp_done);
    chk("paddr",    paddr,    exp_paddr);
    chk("pwrite",   pwrite,   1'b0);
    chk("rsp_data", rsp_data, exp_rdata);
    chk("rsp_err",  rsp_err,  exp_rerr);
    done_prev = exp_done;

    // slave response for the cycle now in progress
    if (acc_now) begin
      pready  = !x_stuck && ((cyc - x_s) > x_waits);
      prdata  = paddr ^ 8'hA5;
      pslverr = paddr > 8'd7;
      if (allow_drop && $urandom_range(0, 3) == 0) dropped[x_own] = 1'b1;
    end else begin
      pready  = 1'($urandom);
      prdata  = 8'($urandom);
      pslverr = 1'($urandom);
    end

    if (done_now) begin
      last_lat       = cyc - req_start[x_own];
      pend[x_own]    = 1'b0;
      dropped[x_own] = 1'b0;
      void'(aq[x_own].pop_front());
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && aq[i].size() > 0 && (hold_mode || $urandom_range(0, 2) == 0)) begin
        pend[i]      = 1'b1;
        req_start[i] = cyc;
      end
      req[i]              = pend[i] && !dropped[i];
      req_addr[i*8 +: 8]  = pend[i] ? aq[i][0] : 8'($urandom);
    end
  endtask

  task automatic drain(input int maxc, input string tag);
    int n = 0;
    while (work_left() && n < maxc) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, work_left(), 1'b0);
    step();
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_psel"},     psel,     1'b0);
    chk({tag, "_penable"},  penable,  1'b0);
    chk({tag, "_gnt"},      gnt,      '0);
    chk({tag, "_busy"},     busy,     1'b0);
    chk({tag, "_done"},     done,     '0);
    chk({tag, "_paddr"},    paddr,    8'h00);
    chk({tag, "_rsp_data"}, rsp_data, 8'h00);
    chk({tag, "_rsp_err"},  rsp_err,  1'b0);
    chk({tag, "_pwrite"},   pwrite,   1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    preset = 1'b1; req = '0; req_addr = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    hold_mode = 1'b1; allow_drop = 1'b0; stuck = 1'b0; rand_stuck = 1'b0; wait_fixed = 0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; dropped[i] = 1'b0; req_start[i] = 0; end
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge pclk);
    @(negedge pclk);
    check_reset_outputs("por_clk");
    preset = 1'b0;

    // single read, zero waits
    aq[0].push_back(8'h03);
    drain(50, "single");
    chk("single_latency", last_lat, 3);
    chk("single_data", rsp_data, 8'hA6);
    chk("single_err", rsp_err, 1'b0);

    // contention, both held
    win_log.delete(); setup_log.delete();
    for (int j = 0; j < 4; j++) begin aq[0].push_back(8'h01); aq[1].push_back(8'h02); end
    drain(100, "contend");
    chk("contend_count", win_log.size(), 8);
    for (int j = 1; j < win_log.size(); j++) begin
      chk("contend_alternate", win_log[j], 1 - win_log[j-1]);
      chk("contend_period", setup_log[j] - setup_log[j-1], 3);
    end

    // wait states plus slave error
    wait_fixed = 2;
    aq[0].push_back(8'h08);
    drain(50, "werr");
    chk("werr_err", rsp_err, 1'b1);
    chk("werr_data", rsp_data, 8'hAD);

    // watchdog, then a normal transfer
    wait_fixed = 0; stuck = 1'b1;
    aq[1].push_back(8'h05);
    drain(60, "wdog");
    chk("wdog_data", rsp_data, 8'h00);
    chk("wdog_err", rsp_err, 1'b1);
    stuck = 1'b0;
    aq[1].push_back(8'h06);
    drain(50, "wdog_next");
    chk("wdog_next_data", rsp_data, 8'hA3);
    chk("wdog_next_err", rsp_err, 1'b0);

    // reset during an ACCESS wait state
    wait_fixed = 8;
    aq[0].push_back(8'h09);
    aq[1].push_back(8'h04);
    n = 0;
    while (!(inflight && (cyc - x_s) == 3) && n < 40) begin step(); n++; end
    chk("rst_reached_access", inflight && (cyc - x_s) == 3, 1'b1);
    #2 preset = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(negedge pclk);
    check_reset_outputs("rst_held");
    preset = 1'b0;
    model_reset();
    wait_fixed = 0;
    win_log.delete();
    drain(100, "post_rst");
    if (win_log.size() > 0) chk("post_rst_first_winner", win_log[0], 0);
    else chk("post_rst_grant_seen", 0, 1);

    // sweep of addresses on requester 1
    for (int a = 0; a <= 8; a++) aq[1].push_back(8'(a));
    drain(100, "sweep");
    chk("sweep_last_err", rsp_err, 1'b1);

    // randomized traffic
    hold_mode = 1'b0; allow_drop = 1'b1; rand_stuck = 1'b1; wait_fixed = -1;
    for (int j = 0; j < 30; j++) begin
      aq[0].push_back(8'($urandom_range(0, 15)));
      aq[1].push_back(8'($urandom_range(0, 15)));
    end
    drain(5000, "random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/encoder_apb_arbiter.md
# encoder_apb_arbiter

APB read master that shares the encoder block's APB slave port between `NREQ` independent requesters. Each requester posts an 8-bit register address. The arbiter picks one requester per transfer in round-robin order and runs a standard APB read (SETUP, then ACCESS, with wait states). It returns `prdata`/`pslverr` to the winner with a one-cycle done pulse. A wait-state watchdog stops a hung slave from stalling the bus forever.

## Interface
Parameters:
- `NREQ`, 2: number of requesters; range 2–8.
- `TIMEOUT`, 16: maximum ACCESS cycles with `pready`=0 before the transfer is aborted. 0 disables the watchdog.

Ports:
- `pclk` in 1: single clock; all state updates on the rising edge.
- `preset` in 1: asynchronous, active-high reset.
- `req` in NREQ: per-requester request. Held high, with its address stable, until that requester's `done` bit pulses.
- `req_addr` in NREQ*8: requester i address in bits [8i+7:8i].
- `gnt` out NREQ: one-hot; high for the requester currently owning the bus (SETUP and ACCESS).
- `done` out NREQ: one-hot, one-cycle completion pulse.
- `rsp_data` out 8: read data, valid while any `done` bit is high.
- `rsp_err` out 1: high with `done` if `pslverr` was seen or the watchdog fired.
- `busy` out 1: high in SETUP and ACCESS.
- `psel`, `penable`, `pwrite` out 1 each: APB master controls. `pwrite` is always 0 (read-only master).
- `paddr` out 8: APB address.
- `prdata` in 8: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- **IDLE**
  - Bus outputs: `psel`=0, `penable`=0.
  - Eligible requesters: `req[i]`=1 and requester i is not masked. The mask covers only the requester whose `done` is high in this same cycle.
  - If any requester is eligible: grant the first eligible index searching upward from `last+1` (mod NREQ). Latch its address into `paddr`, set `gnt`, set `last` to that index, go to SETUP.
- **SETUP**
  - Bus outputs: `psel`=1, `penable`=0.
  - Always moves to ACCESS next cycle; clears the wait counter.
- **ACCESS**
  - Bus outputs: `psel`=1, `penable`=1.
  - `pready`=1: capture `prdata` into `rsp_data` and `pslverr` into `rsp_err`. Pulse `done[gnt]` in the next cycle, clear `gnt`, drop `psel`/`penable`, go to IDLE.
  - `pready`=0: increment the wait counter. If the counter reaches `TIMEOUT` (and `TIMEOUT`≠0), abort:
    - `rsp_data`=8'h00, `rsp_err`=1;
    - `done` pulses next cycle;
    - go to IDLE.
- `paddr` holds its value from SETUP until the next grant.
- `rsp_data`/`rsp_err` hold their last value after `done` falls.
- Round-robin pointer `last` resets to NREQ-1, so requester 0 wins first after reset.
- A requester that drops `req` before its `done` has no effect on an in-flight transfer; it still receives its `done` pulse.
- Simultaneous events:
  - A new `req` arriving while busy waits; it is evaluated in the next IDLE.
  - In the `done` cycle, the just-served requester is masked. If no other requester is pending, the IDLE cycle lasts one more cycle before that requester can be re-granted.
- Reset (including mid-transfer): state=IDLE, `last`=NREQ-1, wait counter=0. Output reset values, asserted immediately and asynchronously:
  - `psel`=0, `penable`=0, `pwrite`=0, `paddr`=8'h00;
  - `gnt`=0, `done`=0, `rsp_data`=8'h00, `rsp_err`=0, `busy`=0.
  - No `done` is issued for the aborted transfer.

## Timing
- Zero-wait slave:
  - `req` sampled high at edge 0;
  - SETUP in cycle 1;
  - ACCESS in cycle 2, with `pready` sampled there;
  - `done` in cycle 3.
  - Request-to-`done` latency is 3 cycles.
- Each wait state adds 1 cycle.
- Back-to-back transfers to different requesters: SETUP begins 1 cycle after the previous ACCESS (IDLE lasts one cycle). Minimum period is 3 cycles per transfer.
- Watchdog: with `pready` stuck at 0, ACCESS lasts exactly `TIMEOUT` cycles and `done` follows 1 cycle later.
- `paddr`, `pwrite` and `psel` are stable from SETUP through the last ACCESS cycle (APB compliant).

## Test plan
Defaults throughout: NREQ=2, TIMEOUT=16. The bench APB slave model returns `prdata` = `paddr` ^ 8'hA5, has a programmable wait count, and asserts `pslverr` for `paddr`>7.
- Single read: `req[0]`=1, addr 8'h03, zero waits → SETUP/ACCESS with `paddr`=8'h03; `done`=2'b01 exactly 3 cycles after `req`; `rsp_data`=8'hA6, `rsp_err`=0.
- Contention: `req`=2'b11 held, addrs 8'h01/8'h02, both re-requested 4 times → grants alternate 0,1,0,1…; `rsp_data` alternates 8'hA4/8'hA7; transfers start every 3 cycles.
- Wait states plus error: addr 8'h08 with 2 wait cycles → ACCESS lasts 3 cycles, `paddr` is stable throughout; `done[0]` with `rsp_err`=1.
- Watchdog: `pready` held at 0 → exactly 16 ACCESS cycles, then `done` with `rsp_data`=8'h00, `rsp_err`=1; the next request completes normally.
- Reset mid-ACCESS: assert `preset` during a wait state → `psel`/`penable`/`gnt`/`busy` drop to 0 without waiting for a clock edge; no `done` pulse; after release, requester 0 wins first.
- Sweep: requester 1 reads addrs 0..8 sequentially → data 8'hA5..8'hAD; error flagged only on addr 8.
